// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe
//   Registered bitwise logic unit with a 2-entry output queue. Each accepted
//   transaction applies one of eight bitwise operations to in1/in2. The result
//   is queued together with its zero and all-ones flags.
//
//   Ports
//     clk, rst             clock and synchronous active-high reset
//     in_valid / in_ready  operand handshake (op, in1, in2 sampled on accept)
//     out_valid/ out_ready result handshake (out, zero, ones show the head entry)
//     parity               XOR-reduction of the head result (optional)
//
//   Build option
//     LOGIC_PARITY_EN  when defined, adds the parity port and per-entry parity
//                      storage.
//
//   op: 000 OR, 001 AND, 010 XOR, 011 NOR, 100 NAND, 101 XNOR,
//       110 NOT in1, 111 PASS in1
module logic_unit_pipe #(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [SIZE-1:0] in1,
  input  logic [SIZE-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [SIZE-1:0] out,
  output logic            zero,
  output logic            ones
`ifdef LOGIC_PARITY_EN
  ,
  output logic            parity
`endif
);

  function automatic logic [SIZE-1:0] logic_op(input logic [2:0]      sel,
                                                input logic [SIZE-1:0] a,
                                                input logic [SIZE-1:0] b);
    logic [SIZE-1:0] r;
    case (sel)
      3'b000:  r = a | b;
      3'b001:  r = a & b;
      3'b010:  r = a ^ b;
      3'b011:  r = ~(a | b);
      3'b100:  r = ~(a & b);
      3'b101:  r = ~(a ^ b);
      3'b110:  r = ~a;
      default: r = a;
    endcase
    return r;
  endfunction

  // Stage p0: combinational result and flags from the sampled operands
  logic [SIZE-1:0] res_p0;
  logic            zero_p0;
  logic            ones_p0;
  logic            accept;
  logic            drain;

  assign res_p0  = logic_op(op, in1, in2);
  assign zero_p0 = (res_p0 == '0);
  assign ones_p0 = (res_p0 == '1);

  // Stage p1: queue storage. Head drives the outputs directly; tail holds the
  // second entry. Only the head is reset, because out/zero/ones must read 0
  // after reset.
  logic [1:0]      count_p1;
  logic [SIZE-1:0] head_data_p1;
  logic            head_zero_p1;
  logic            head_ones_p1;
  logic [SIZE-1:0] tail_data_p1;
  logic            tail_zero_p1;
  logic            tail_ones_p1;
`ifdef LOGIC_PARITY_EN
  logic            par_p0;
  logic            head_par_p1;
  logic            tail_par_p1;
  assign par_p0 = ^res_p0;
`endif

  assign in_ready  = ~rst & (count_p1 != 2'd2);
  assign out_valid = (count_p1 != 2'd0);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_p1     <= 2'd0;
      head_data_p1 <= '0;
      head_zero_p1 <= 1'b0;
      head_ones_p1 <= 1'b0;
`ifdef LOGIC_PARITY_EN
      head_par_p1  <= 1'b0;
`endif
    end else begin
      count_p1 <= count_p1 + {1'b0, accept} - {1'b0, drain};
      // A new entry goes straight to the head when the queue is empty, or
      // when the single entry it holds is being popped on the same edge.
      if (accept && (count_p1 == 2'd0 || drain)) begin
        head_data_p1 <= res_p0;
        head_zero_p1 <= zero_p0;
        head_ones_p1 <= ones_p0;
`ifdef LOGIC_PARITY_EN
        head_par_p1  <= par_p0;
`endif
      end else if (accept) begin
        tail_data_p1 <= res_p0;
        tail_zero_p1 <= zero_p0;
        tail_ones_p1 <= ones_p0;
`ifdef LOGIC_PARITY_EN
        tail_par_p1  <= par_p0;
`endif
      end else if (drain && count_p1 == 2'd2) begin
        head_data_p1 <= tail_data_p1;
        head_zero_p1 <= tail_zero_p1;
        head_ones_p1 <= tail_ones_p1;
`ifdef LOGIC_PARITY_EN
        head_par_p1  <= tail_par_p1;
`endif
      end
    end
  end

  // Popping the last entry leaves the head registers untouched, so the
  // outputs keep showing the last popped values while the queue is empty.
  assign out  = head_data_p1;
  assign zero = head_zero_p1;
  assign ones = head_ones_p1;
`ifdef LOGIC_PARITY_EN
  assign parity = head_par_p1;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed testbench for logic_unit_pipe (SIZE=8). Inputs are driven 1 time
// unit after each rising edge, and outputs are sampled at that same point.
module tb_logic_unit_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out;
  logic       zero;
  logic       ones;
`ifdef LOGIC_PARITY_EN
  logic       parity;
`endif

  int checks   = 0;
  int failures = 0;

  logic_unit_pipe #(.SIZE(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in1(in1), .in2(in2), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .zero(zero), .ones(ones)
`ifdef LOGIC_PARITY_EN
    , .parity(parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1; op = o; in1 = a; in2 = b;
    step();
    in_valid = 1'b0;
  endtask

  logic [7:0] sweep_exp [8] = '{8'hFC, 8'h30, 8'hCC, 8'h03, 8'hCF, 8'h33, 8'h0F, 8'hF0};

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 3'd0; in1 = 8'h00; in2 = 8'h00; out_ready = 1'b1;
    step(); step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_zero", zero, 0);
    chk("rst_ones", ones, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", in_ready, 1);

    // OR basic, one-cycle valid
    push(3'b000, 8'hAA, 8'hCC);
    chk("or_valid", out_valid, 1);
    chk("or_out", out, 8'hEE);
    chk("or_zero", zero, 0);
    chk("or_ones", ones, 0);
`ifdef LOGIC_PARITY_EN
    chk("par_ee", parity, 0);
`endif
    step();
    chk("or_valid_drop", out_valid, 0);
    chk("empty_hold", out, 8'hEE);

    // flags
    push(3'b000, 8'hFF, 8'h00);
    chk("ones_out", out, 8'hFF);
    chk("ones_flag", ones, 1);
    chk("ones_zero", zero, 0);
    push(3'b011, 8'hFF, 8'h00);
    chk("nor_out", out, 8'h00);
    chk("nor_zero", zero, 1);
    chk("nor_ones", ones, 0);
    step();

    // op sweep as a continuous stream (accept+drain at count 1)
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; op = 3'(i); in1 = 8'hF0; in2 = 8'h3C;
      chk("stream_in_ready", in_ready, 1);
      step();
      chk($sformatf("sweep_op%0d", i), out, sweep_exp[i]);
      chk("sweep_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    step();
    chk("sweep_empty", out_valid, 0);

    // backpressure
    out_ready = 1'b0;
    push(3'b000, 8'h01, 8'h02);
    chk("bp_out1", out, 8'h03);
    chk("bp_ready1", in_ready, 1);
    push(3'b001, 8'h10, 8'h30);
    chk("bp_full", in_ready, 0);
    in_valid = 1'b1; op = 3'b111; in1 = 8'h55; in2 = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_hold", out, 8'h03);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_full", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("bp_head", out, 8'h03);
    step();
    chk("bp_second", out, 8'h10);
    chk("bp_second_valid", out_valid, 1);
    step();
    chk("bp_drained", out_valid, 0);
    chk("bp_drained_hold", out, 8'h10);

    // reset mid-operation with two entries queued
    out_ready = 1'b0;
    push(3'b000, 8'h0F, 8'h00);
    push(3'b000, 8'hF0, 8'h00);
    chk("pre_rst_full", in_ready, 0);
    rst = 1'b1;
    #1;
    chk("rst_mid_in_ready", in_ready, 0);
    step();
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_out", out, 0);
    chk("rst_mid_in_ready2", in_ready, 0);
    rst = 1'b0;
    #1;
    chk("rst_mid_release", in_ready, 1);
    out_ready = 1'b1;
    push(3'b010, 8'hAA, 8'hCC);
    chk("post_rst_xor", out, 8'h66);
    chk("post_rst_valid", out_valid, 1);
    step();
    chk("post_rst_empty", out_valid, 0);

`ifdef LOGIC_PARITY_EN
    push(3'b111, 8'h07, 8'h00);
    chk("par_07", parity, 1);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
